// File: rtl/mem_pkg.sv
// Shared sizing constants and FSM state encoding for the mem_reader block.
package mem_pkg;

    localparam int MEM_AW    = 6;
    localparam int MEM_DW    = 8;
    localparam int MEM_DEPTH = 64;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        DRAIN = 3'd2,
        CHK   = 3'd3,
        DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/mem_reader_fifo.sv
// Two-entry FIFO buffering read data between the memory port and the output stream.
// Push and pop may occur in the same cycle, including when full.
module mem_reader_fifo
    import mem_pkg::*;
#(
    parameter int DW = MEM_DW
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_push,
    input  logic [DW-1:0] i_data,
    input  logic          i_pop,
    output logic [DW-1:0] o_data,
    output logic [1:0]    o_count,
    output logic          o_full,
    output logic          o_empty
);

    logic [DW-1:0] r_mem [2];
    logic          r_wr_ptr;
    logic          r_rd_ptr;
    logic [1:0]    r_count;
    logic          w_push;
    logic          w_pop;

    assign o_empty = (r_count == 2'd0);
    assign o_full  = (r_count == 2'd2);
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd_ptr];

    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign w_pop  = i_pop & ~o_empty;
    assign w_push = i_push & (~o_full | w_pop);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            // NOTE: storage is reset too, so the stream output reads zero straight out of reset.
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/mem_reader.sv
// Scans DEPTH words of a one-cycle-latency memory and streams them out over Valid/Ready.
// Optional trailing checksum byte enabled by defining MEM_READER_CHKSUM_EN.
module mem_reader
    import mem_pkg::*;
#(
    parameter int AW    = MEM_AW,
    parameter int DW    = MEM_DW,
    parameter int DEPTH = MEM_DEPTH
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          start,
    output logic [AW-1:0] AB,
    output logic          RdEn,
    input  logic [DW-1:0] DB,
    output logic [DW-1:0] Dout,
    output logic          Valid,
    input  logic          Ready,
    output logic          Busy,
    output logic          Done
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    state_t        r_state;
    state_t        w_next;
    logic [AW-1:0] r_addr;
    logic          r_inflight;
    logic          w_rd_en;
    logic          w_pop;
    logic [2:0]    w_level;
    logic [DW-1:0] w_fifo_data;
    logic [1:0]    w_fifo_count;
    logic          w_fifo_full;
    logic          w_fifo_empty;

    mem_reader_fifo #(.DW(DW)) u_fifo (
        .i_clk   (Clk),
        .i_rst_n (Rst),
        .i_push  (r_inflight),
        .i_data  (DB),
        .i_pop   (w_pop),
        .o_data  (w_fifo_data),
        .o_count (w_fifo_count),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    assign w_pop = ~w_fifo_empty & Ready;

    // Occupancy after this cycle's pop, counting the read whose data lands next edge;
    // crediting the pop is what sustains one byte per cycle with a 2-entry FIFO.
    assign w_level = {1'b0, w_fifo_count} + {2'b00, r_inflight} - {2'b00, w_pop};

    always_comb begin
        // NOTE: defaults first so no branch can leave a latch behind.
        w_next  = r_state;
        w_rd_en = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) w_next = READ;
            end
            READ: begin
                if ((w_level < 3'd2) && !w_fifo_full) begin
                    w_rd_en = 1'b1;
                    if (r_addr == LAST_ADDR) w_next = DRAIN;
                end
            end
            DRAIN: begin
                if (w_fifo_empty && !r_inflight) begin
`ifdef MEM_READER_CHKSUM_EN
                    w_next = CHK;
`else
                    w_next = DONE;
`endif
                end
            end
`ifdef MEM_READER_CHKSUM_EN
            CHK: begin
                if (Ready) w_next = DONE;
            end
`endif
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            r_state    <= IDLE;
            r_addr     <= '0;
            r_inflight <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_inflight <= w_rd_en;
            if (r_state == IDLE) begin
                r_addr <= '0;
            end else if (w_rd_en) begin
                r_addr <= r_addr + AW'(1);
            end
        end
    end

`ifdef MEM_READER_CHKSUM_EN
    logic [7:0] r_sum;

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            r_sum <= 8'd0;
        end else if ((r_state == IDLE) && start) begin
            r_sum <= 8'd0;
        end else if (w_pop) begin
            r_sum <= r_sum + 8'(w_fifo_data);
        end
    end

    assign Dout  = (r_state == CHK) ? DW'(r_sum) : w_fifo_data;
    assign Valid = ~w_fifo_empty | (r_state == CHK);
`else
    assign Dout  = w_fifo_data;
    assign Valid = ~w_fifo_empty;
`endif

    assign AB   = r_addr;
    assign RdEn = w_rd_en;
    assign Busy = (r_state != IDLE);
    assign Done = (r_state == DONE);

endmodule

// File: tb/tb_mem_reader.sv
// Scoreboard bench for mem_reader: expected bytes queued at stimulus time, checked by a monitor.
// Honours MEM_READER_CHKSUM_EN to expect the trailing checksum byte.
module tb_mem_reader;

`ifdef MEM_READER_CHKSUM_EN
    localparam int N_EXP = 65;
`else
    localparam int N_EXP = 64;
`endif

    logic       Clk = 1'b0;
    logic       Rst = 1'b0;
    logic       start = 1'b0;
    logic [5:0] AB;
    logic       RdEn;
    logic [7:0] DB = 8'd0;
    logic [7:0] Dout;
    logic       Valid;
    logic       Ready = 1'b0;
    logic       Busy;
    logic       Done;

    mem_reader dut (
        .Clk   (Clk),
        .Rst   (Rst),
        .start (start),
        .AB    (AB),
        .RdEn  (RdEn),
        .DB    (DB),
        .Dout  (Dout),
        .Valid (Valid),
        .Ready (Ready),
        .Busy  (Busy),
        .Done  (Done)
    );

    always #5 Clk = ~Clk;

    logic [7:0] mem [64];
    initial for (int i = 0; i < 64; i++) mem[i] = 8'(i + 1);
    always @(posedge Clk) if (RdEn) DB <= mem[AB];

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Ready driver: 0 = held low, 1 = held high, 2 = repeating 1,0,0,1
    int ready_mode = 0;
    int rcyc = 0;
    initial forever begin
        @(posedge Clk);
        #1;
        rcyc++;
        case (ready_mode)
            0:       Ready = 1'b0;
            1:       Ready = 1'b1;
            default: Ready = ((rcyc % 4) == 0) || ((rcyc % 4) == 3);
        endcase
    end

    // Monitor / scoreboard
    logic [7:0] q[$];
    int tr_n = 0, done_cnt = 0, rd_cnt = 0, cyc = 0, out_n = 0;
    int tr_cyc [70];
    logic prev_rd = 0, prev_v = 0, prev_r = 0;
    logic [7:0] prev_d = 0;

    initial forever begin
        logic xfer;
        logic [7:0] exp_b;
        @(negedge Clk);
        cyc++;
        if (!Rst) begin
            out_n  = 0;
            prev_rd = 0;
            prev_v = 0;
        end else begin
            if (RdEn) begin
                rd_cnt++;
                check("rden_with_fifo_full", 32'((out_n - int'(prev_rd)) < 2), 32'd1);
            end
            if (prev_v && !prev_r) begin
                check("stall_valid_held", 32'(Valid), 32'd1);
                check("stall_dout_held", 32'(Dout), 32'(prev_d));
            end
            xfer = Valid && Ready;
            if (xfer) begin
                if (q.size() == 0) begin
                    check("unexpected_extra_byte", 32'(q.size()), 32'd1);
                end else begin
                    exp_b = q.pop_front();
                    check("stream_byte", 32'(Dout), 32'(exp_b));
                end
                if (tr_n < 70) tr_cyc[tr_n] = cyc;
                tr_n++;
            end
            if (Done) done_cnt++;
            out_n = out_n + int'(RdEn) - ((xfer && out_n > 0) ? 1 : 0);
            prev_rd = RdEn;
            prev_v  = Valid;
            prev_r  = Ready;
            prev_d  = Dout;
        end
    end

    task automatic load_expect();
        q.delete();
        for (int i = 0; i < 64; i++) q.push_back(8'(i + 1));
`ifdef MEM_READER_CHKSUM_EN
        q.push_back(8'h20);
`endif
        tr_n = 0;
        done_cnt = 0;
        rd_cnt = 0;
    endtask

    task automatic pulse_start();
        @(posedge Clk);
        #1 start = 1'b1;
        @(posedge Clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_bytes(input int n);
        int k;
        for (k = 0; k < 400; k++) begin
            @(negedge Clk);
            #1;
            if (tr_n >= n) break;
        end
        check("wait_bytes_reached", 32'(tr_n >= n), 32'd1);
    endtask

    task automatic wait_done(input string tag);
        int k;
        for (k = 0; k < 400; k++) begin
            @(negedge Clk);
            if (Done) break;
        end
        check({tag, "_done_seen"}, 32'(Done), 32'd1);
        @(negedge Clk);
        check({tag, "_done_one_cycle"}, 32'(Done), 32'd0);
        check({tag, "_busy_falls"}, 32'(Busy), 32'd0);
        @(negedge Clk);
        #1;
        check({tag, "_done_count"}, 32'(done_cnt), 32'd1);
        check({tag, "_bytes_out"}, 32'(tr_n), 32'(N_EXP));
        check({tag, "_queue_empty"}, 32'(q.size()), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_AB"}, 32'(AB), 32'd0);
        check({tag, "_RdEn"}, 32'(RdEn), 32'd0);
        check({tag, "_Dout"}, 32'(Dout), 32'd0);
        check({tag, "_Valid"}, 32'(Valid), 32'd0);
        check({tag, "_Busy"}, 32'(Busy), 32'd0);
        check({tag, "_Done"}, 32'(Done), 32'd0);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout, want self-termination");
        $fatal(1);
    end

    initial begin
        bit seen_v;

        // Reset values
        ready_mode = 1;
        repeat (3) @(posedge Clk);
        #1 Rst = 1'b1;
        @(negedge Clk);
        check_all_zero("reset");

        // Ready held high: latency, ordering, back-to-back throughput
        load_expect();
        pulse_start();
        @(negedge Clk);
        check("first_read_en", 32'(RdEn), 32'd1);
        check("first_read_addr", 32'(AB), 32'd0);
        check("valid_after_1", 32'(Valid), 32'd0);
        @(negedge Clk);
        check("valid_after_1b", 32'(Valid), 32'd0);
        @(negedge Clk);
        check("valid_after_2", 32'(Valid), 32'd1);
        check("first_dout", 32'(Dout), 32'h01);
        wait_done("full_rate");
        check("back_to_back_64", 32'(tr_cyc[63] - tr_cyc[0]), 32'd63);

        // Ready toggling 1,0,0,1
        ready_mode = 2;
        load_expect();
        pulse_start();
        wait_done("toggle");

        // start re-pulsed mid-scan is ignored
        ready_mode = 1;
        load_expect();
        pulse_start();
        wait_bytes(10);
        pulse_start();
        wait_done("start_ignored");

        // Reset after byte 20 aborts the scan
        load_expect();
        pulse_start();
        wait_bytes(20);
        @(posedge Clk);
        #1 Rst = 1'b0;
        @(posedge Clk);
        #1 Rst = 1'b1;
        @(negedge Clk);
        check_all_zero("midscan_reset");
        q.delete();
        seen_v = 1'b0;
        repeat (10) begin
            @(negedge Clk);
            if (Valid) seen_v = 1'b1;
        end
        check("no_valid_after_reset", 32'(seen_v), 32'd0);
        load_expect();
        pulse_start();
        wait_done("restart");

        // Ready low for 50 cycles at scan start
        ready_mode = 0;
        repeat (2) @(posedge Clk);
        load_expect();
        pulse_start();
        repeat (50) @(negedge Clk);
        #1;
        check("stall_valid", 32'(Valid), 32'd1);
        check("stall_dout", 32'(Dout), 32'h01);
        check("stall_reads_le2", 32'(rd_cnt <= 2), 32'd1);
        check("stall_nothing_taken", 32'(q.size()), 32'(N_EXP));
        ready_mode = 1;
        wait_done("stall_resume");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_reader.md
MEM_READER -- requirements
Module: mem_reader

Interface
REQ-001 SHALL have parameters: AW, 6, address width; DW, 8, data width; DEPTH, 64, words scanned per run.
REQ-002 SHALL have ports: Clk  in  1  single clock, all logic on rising edge.
REQ-003 SHALL have ports: Rst  in  1  synchronous reset, active-low (Rst=0 resets on the next Clk edge).
REQ-004 SHALL have ports: start  in  1  one-cycle request to begin a scan.
REQ-005 SHALL have ports: AB  out  AW  memory read address; RdEn  out  1  read strobe; DB  in  DW  read data, valid exactly one cycle after RdEn.
REQ-006 SHALL have ports: Dout  out  DW  stream byte; Valid  out  1; Ready  in  1.
REQ-007 SHALL have ports: Busy  out  1  scan in progress; Done  out  1  one-cycle completion pulse.

Function
REQ-008 SHALL implement FSM states IDLE, READ, DRAIN, CHK, DONE.
REQ-009 IDLE: start=1 -> READ next cycle; address counter cleared to 0; start ignored in any state other than IDLE.
REQ-010 READ: assert RdEn with AB=counter when (fifo_count + inflight) < 2; counter increments per issued read.
REQ-011 After the read of address DEPTH-1 is issued -> DRAIN; the address counter does not wrap into a second pass.
REQ-012 Read data captured into a 2-entry FIFO the cycle after RdEn; FIFO never overflows under any Ready pattern.
REQ-013 Valid = FIFO non-empty; Dout = FIFO head; a transfer occurs when Valid & Ready in the same cycle.
REQ-014 Dout and Valid SHALL remain stable while Valid=1 and Ready=0.
REQ-015 Simultaneous FIFO push and pop in one cycle SHALL keep the count unchanged and preserve order.
REQ-016 DRAIN: when the FIFO is empty with no read in flight -> CHK if the checksum feature is enabled, else DONE.
REQ-017 DONE: Done=1 for exactly one cycle, then IDLE; Busy=1 in READ, DRAIN, CHK and DONE.
REQ-018 Throughput with Ready held at 1: one byte per cycle; first Valid 2 cycles after start.
REQ-019 Output bytes SHALL appear in address order 0..DEPTH-1, each exactly once.

Reset
REQ-020 On Rst=0 at a Clk edge: state=IDLE, counter=0, FIFO emptied, in-flight read discarded.
REQ-021 Reset values: AB=0, RdEn=0, Dout=0, Valid=0, Busy=0, Done=0.
REQ-022 Reset mid-scan SHALL abort with no further Valid; the next start begins again at address 0.

Configuration
REQ-023 Macro MEM_READER_CHKSUM_EN SHALL control the checksum feature.
REQ-024 Macro defined: an 8-bit accumulator sums every transferred data byte modulo 256; CHK presents the sum as one extra Valid byte and holds it until Ready, then -> DONE.
REQ-025 Macro undefined: no accumulator and no CHK state logic; DRAIN goes directly to DONE; exactly DEPTH bytes are output.

Structure
REQ-026 Shared package mem_pkg SHALL hold MEM_AW=6, MEM_DW=8, MEM_DEPTH=64 and the FSM state encodings.
REQ-027 The 2-entry FIFO SHALL be a sub-module mem_reader_fifo (push, pop, data, count, full, empty).

Verification
REQ-028 Load mem[i]=i+1 for i=0..63, pulse start, hold Ready=1 -> bytes 0x01..0x40 on 64 consecutive cycles; Done pulses once; Busy then falls.
REQ-029 Same memory, macro defined -> 65th byte = 0x20 (sum 2080 mod 256), then Done.
REQ-030 Same memory, Ready toggling 1,0,0,1 -> sequence 0x01..0x40 intact with no drop or duplicate; Dout stable while stalled; RdEn never raised with the FIFO full.
REQ-031 Pulse start at byte 10 of a scan -> ignored; exactly 64 bytes, one Done.
REQ-032 Drive Rst=0 for one cycle after byte 20 -> all outputs 0 next cycle; a new start restarts with 0x01.
REQ-033 Ready=0 for 50 cycles at scan start -> Valid held with Dout=0x01; RdEn issues at most 2 reads; resumes correctly when Ready returns.
